multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Moore/Mealy FSM that sequences the multi-cycle MIPS-subset datapath (PC, IR, regfile, ALU, shared
//  instr/data memory) one step per clock: fetch, decode, execute, memory, write-back. Covers R-type
//  (incl. jr), j, jal, beq/bnez/blt/ble, addi, ori, li, lw, sw. Adds a memory-ready handshake, a
//  wait timeout, a sticky error state and a retired-instruction counter.
// PARAMETERS
//  MEM_TIMEOUT  15  max consecutive cycles with mem_ready_i low in a memory-access state before ERR
//  CNT_W        16  width of instr_cnt_o
// PORTS
//  clk_i          in   1      clock, rising edge
//  rst_i          in   1      asynchronous reset, active-high
//  start_i        in   1      leave IDLE and begin fetching
//  instr_op_i     in   6      IR[31:26]
//  instr_funct_i  in   6      IR[5:0]
//  cond_i         in   1      branch condition from datapath comparator for branch_type_o
//  mem_ready_i    in   1      memory completes the current read/write this cycle
//  pc_write_o     out  1      PC load enable
//  pc_src_o       out  2      0 ALU(PC+4) 1 ALUOut(branch tgt) 2 jump tgt 3 rs (jr)
//  ir_write_o     out  1      IR load enable
//  iord_o         out  1      memory address: 0 PC, 1 ALUOut
//  mem_read_o / mem_write_o  out 1 each  memory strobes
//  reg_write_o    out  1      regfile write enable
//  reg_dst_o      out  2      0 rt 1 rd 2 $31
//  mem_to_reg_o   out  2      0 ALUOut 1 MDR 2 immediate 3 PC(+4)
//  alu_src_a_o    out  1      0 PC, 1 rs
//  alu_src_b_o    out  2      0 rt 1 const 4 2 sext imm 3 sext imm<<2
//  alu_op_o       out  4      0 R 1 jal 2 beq 3 bnez 4 blt 5 ble 6 add 7 ori 8 lw 9 sw
//  branch_type_o  out  2      0 beq 1 ble 2 blt 3 bnez
//  state_o        out  4      current state encoding (debug)
//  retire_o       out  1      1-cycle pulse in last cycle of each instruction
//  instr_cnt_o    out  CNT_W  retired instructions, wraps modulo 2^CNT_W
//  illegal_o / timeout_o  out 1 each  sticky error flags
// BEHAVIOUR
//  Reset (async, immediate, any state): state IDLE; every output 0; counters/flags cleared.
//  All unused selects drive 0 (no X). Only assertions listed per state; all else 0.
//  IDLE: start_i=1 -> FETCH.
//  FETCH: mem_read=1 iord=0 src_a=0 src_b=1 alu_op=6. ready=1 (zero-wait allowed): ir_write=1,
//   pc_write=1 pc_src=0 -> DECODE; else stay.
//  DECODE: src_a=0 src_b=3 alu_op=6 (branch target). instr_op_i/funct_i valid here (IR stable).
//   op0&funct 0x08->JR; op0->EXEC_R; 2->JUMP; 3->JAL; 4..7->BRANCH; 8,13->EXEC_I; 15->WB_LI;
//   35,43->MEM_ADDR; other -> ERR, illegal_o=1.
//  EXEC_R: src_a=1 src_b=0 alu_op=0 -> WB_R: reg_write=1 reg_dst=1 mem_to_reg=0 retire -> FETCH.
//  EXEC_I: src_a=1 src_b=2 alu_op=6(addi)/7(ori) -> WB_I: reg_write=1 reg_dst=0 m2r=0 retire.
//  WB_LI: reg_write=1 reg_dst=0 mem_to_reg=2, retire -> FETCH.
//  BRANCH: src_a=1 src_b=0 alu_op 2..5, branch_type 0/3/2/1 for op 4/5/6/7;
//   pc_write=cond_i (Mealy) pc_src=1; retire -> FETCH.
//  JUMP: pc_write=1 pc_src=2 retire. JAL: same + reg_write=1 reg_dst=2 mem_to_reg=3 alu_op=1.
//  JR: pc_write=1 pc_src=3 retire.
//  MEM_ADDR: src_a=1 src_b=2 alu_op=8(lw)/9(sw) -> MEM_RD/MEM_WR.
//  MEM_RD: mem_read=1 iord=1; ready -> WB_MEM. MEM_WR: mem_write=1 iord=1; ready -> retire, FETCH.
//  WB_MEM: reg_write=1 reg_dst=0 mem_to_reg=1 retire -> FETCH.
//  Strobes held constant until mem_ready_i; wait counter cleared on entry to FETCH/MEM_RD/MEM_WR,
//   +1 per cycle ready low; reaching MEM_TIMEOUT -> ERR, timeout_o=1 (ready in same cycle wins).
//  ERR: all enables/strobes 0, flags held, only rst_i exits; start_i ignored.
//  Latency (zero-wait): R/I/lw-less 4, li/j/jal/jr/branch 3, lw 5, sw 4 cycles.
//  instr_cnt_o increments on the cycle after retire_o; all-ones +1 -> 0.
// TESTING
//  rst_i pulse mid-MEM_RD -> outputs 0 same cycle, IDLE; start_i=1 -> next cycle mem_read=1 iord=0.
//  add (op0 funct 0x20), ready tied 1 -> FETCH,DECODE,EXEC_R,WB_R; WB_R reg_write=1 reg_dst=1; cnt=1.
//  lw op35, ready low 3 cycles in MEM_RD -> mem_read held 4 cycles, 8 cycles total, WB_MEM m2r=1.
//  ble op7 cond_i=0 then beq op4 cond_i=1 -> pc_write 0 / 1, pc_src=1, branch_type 1 / 0.
//  jal op3 -> single cycle reg_write=1 reg_dst=2 mem_to_reg=3 pc_write=1 pc_src=2; jr -> pc_src=3.
//  op 6'd9 -> ERR illegal_o=1 sticky; ready low 15 cycles in FETCH -> timeout_o=1, strobes 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS-subset datapath: one micro-step per clock,
// memory-ready handshake with wait timeout, sticky error flags and a retire counter.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start_i
// FETCH    | read instruction at PC, PC <= PC+4 when memory ready
// DECODE   | IR valid; compute branch target into ALUOut
// EXEC_R   | R-type ALU operation on rs, rt
// EXEC_I   | addi/ori ALU operation on rs, sext imm
// WB_ALU   | write ALUOut to rd (R-type) or rt (addi/ori)
// WB_LI    | write immediate to rt
// BRANCH   | compare rs/rt, conditionally load branch target
// JUMP     | load jump target
// JAL      | load jump target, write PC+4 to $31
// JR       | load PC from rs
// MEM_ADDR | compute rs + sext imm for lw/sw
// MEM_RD   | data read at ALUOut until memory ready
// MEM_WR   | data write at ALUOut until memory ready
// WB_MEM   | write MDR to rt
// ERR      | illegal opcode or memory timeout; left only through reset
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [5:0]       instr_op_i,
    input  logic [5:0]       instr_funct_i,
    input  logic             cond_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             ir_write_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             reg_write_o,
    output logic [1:0]       reg_dst_o,
    output logic [1:0]       mem_to_reg_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [3:0]       alu_op_o,
    output logic [1:0]       branch_type_o,
    output logic [3:0]       state_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic             illegal_o,
    output logic             timeout_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_ALU   = 4'd5,
        S_WB_LI    = 4'd6,
        S_BRANCH   = 4'd7,
        S_JUMP     = 4'd8,
        S_JAL      = 4'd9,
        S_JR       = 4'd10,
        S_MEM_ADDR = 4'd11,
        S_MEM_RD   = 4'd12,
        S_MEM_WR   = 4'd13,
        S_WB_MEM   = 4'd14,
        S_ERR      = 4'd15
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_illegal;
    logic              r_timeout;
    logic              w_is_wait;
    logic              w_timeout_hit;
    logic              w_set_illegal;

    assign w_is_wait     = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_timeout_hit = w_is_wait && !mem_ready_i && (r_wait == WAIT_LAST);

    assign state_o     = r_state;
    assign instr_cnt_o = r_cnt;
    assign illegal_o   = r_illegal;
    assign timeout_o   = r_timeout;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= '0;
            else if (w_is_wait && !mem_ready_i)
                r_wait <= r_wait + 1'b1;
            if (retire_o)
                r_cnt <= r_cnt + 1'b1;
            if (w_set_illegal)
                r_illegal <= 1'b1;
            if (w_timeout_hit)
                r_timeout <= 1'b1;
        end
    end

    // IR stays loaded from DECODE until the next FETCH, so later states may decode op/funct again.
    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        pc_write_o    = 1'b0;
        pc_src_o      = 2'd0;
        ir_write_o    = 1'b0;
        iord_o        = 1'b0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        reg_write_o   = 1'b0;
        reg_dst_o     = 2'd0;
        mem_to_reg_o  = 2'd0;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = 2'd0;
        alu_op_o      = 4'd0;
        branch_type_o = 2'd0;
        retire_o      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_i)
                    w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'd1;
                alu_op_o    = 4'd6;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout_hit) begin
                    w_next = S_ERR;
                end
            end
            S_DECODE: begin
                alu_src_b_o = 2'd3;
                alu_op_o    = 4'd6;
                case (instr_op_i)
                    6'd0:          w_next = (instr_funct_i == 6'h08) ? S_JR : S_EXEC_R;
                    6'd2:          w_next = S_JUMP;
                    6'd3:          w_next = S_JAL;
                    6'd4, 6'd5,
                    6'd6, 6'd7:    w_next = S_BRANCH;
                    6'd8, 6'd13:   w_next = S_EXEC_I;
                    6'd15:         w_next = S_WB_LI;
                    6'd35, 6'd43:  w_next = S_MEM_ADDR;
                    default: begin
                        w_next        = S_ERR;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                w_next      = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                alu_op_o    = (instr_op_i == 6'd13) ? 4'd7 : 4'd6;
                w_next      = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write_o = 1'b1;
                reg_dst_o   = (instr_op_i == 6'd0) ? 2'd1 : 2'd0;
                retire_o    = 1'b1;
                w_next      = S_FETCH;
            end
            S_WB_LI: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'd2;
                retire_o     = 1'b1;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                pc_write_o  = cond_i;
                pc_src_o    = 2'd1;
                retire_o    = 1'b1;
                w_next      = S_FETCH;
                case (instr_op_i)
                    6'd4:    begin alu_op_o = 4'd2; branch_type_o = 2'd0; end
                    6'd5:    begin alu_op_o = 4'd3; branch_type_o = 2'd3; end
                    6'd6:    begin alu_op_o = 4'd4; branch_type_o = 2'd2; end
                    default: begin alu_op_o = 4'd5; branch_type_o = 2'd1; end
                endcase
            end
            S_JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = 2'd2;
                retire_o   = 1'b1;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                pc_write_o   = 1'b1;
                pc_src_o     = 2'd2;
                reg_write_o  = 1'b1;
                reg_dst_o    = 2'd2;
                mem_to_reg_o = 2'd3;
                alu_op_o     = 4'd1;
                retire_o     = 1'b1;
                w_next       = S_FETCH;
            end
            S_JR: begin
                pc_write_o = 1'b1;
                pc_src_o   = 2'd3;
                retire_o   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                if (instr_op_i == 6'd43) begin
                    alu_op_o = 4'd9;
                    w_next   = S_MEM_WR;
                end else begin
                    alu_op_o = 4'd8;
                    w_next   = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                if (mem_ready_i)
                    w_next = S_WB_MEM;
                else if (w_timeout_hit)
                    w_next = S_ERR;
            end
            S_MEM_WR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                if (mem_ready_i) begin
                    retire_o = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_timeout_hit) begin
                    w_next = S_ERR;
                end
            end
            S_WB_MEM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'd1;
                retire_o     = 1'b1;
                w_next       = S_FETCH;
            end
            default: begin
                w_next = S_ERR;
            end
        endcase
    end

endmodule
